wall_v_draw: RTL and testbench

- Per-pixel draw stage for vertical maze wall sprites. Sits between the VGA pixel counter and the colour mapper.
- Holds a table of up to NUM_INST wall placements. The table is written by game logic and committed at frame start.
- For each pixel it tests whether the pixel falls inside a placed wall and drives the sprite ROM address (18x22 sprite, 4-bit palette index, 396 entries).
- Registers the returned index into a pipelined hit/index output for the colour mapper.

---
 rtl/wall_v_draw.sv | 153 +++++++++++++++
 tb/tb_wall_v_draw.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_v_draw.sv
// Per-pixel draw stage for vertical maze wall sprites: double-buffered placement table,
// hit test and sprite ROM addressing, then a two-register hit/index pipeline.
module wall_v_draw #(
  parameter int unsigned SPR_W    = 18,
  parameter int unsigned SPR_H    = 22,
  parameter int unsigned NUM_INST = 8,
  parameter logic [3:0]  TRANSP   = 4'h0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_sync,
  input  logic       pix_valid,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [9:0] wr_x,
  input  logic [9:0] wr_y,
  input  logic       wr_on,
  output logic [8:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic       out_valid,
  output logic       out_hit,
  output logic [3:0] out_idx
);

  localparam int unsigned CW = 10;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 4;
  localparam int unsigned IW = 3;

  logic          sh_on [NUM_INST];
  logic [CW-1:0] sh_x  [NUM_INST];
  logic [CW-1:0] sh_y  [NUM_INST];
  logic          act_on [NUM_INST];
  logic [CW-1:0] act_x  [NUM_INST];
  logic [CW-1:0] act_y  [NUM_INST];

  logic          valid0;
  logic [CW-1:0] x0;
  logic [CW-1:0] y0;

  logic          any_hit;
  logic [CW-1:0] x_sel;
  logic [CW-1:0] y_sel;
  logic [CW-1:0] off_x;
  logic [CW-1:0] off_y;
  logic [AW-1:0] addr_full;
  logic [SW-1:0] px0;
  logic [SW-1:0] py0;

  logic          valid1;
  logic          hit1;
  logic [DW-1:0] data1;

  // Shadow table takes writes; frame_sync copies it to the active table, including a same-cycle write
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(NUM_INST); i++) begin
        sh_on[i]  <= 1'b0;
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        act_on[i] <= 1'b0;
        act_x[i]  <= '0;
        act_y[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_INST); i++) begin
        if (wr_en && (wr_idx == IW'(i))) begin
          sh_on[i] <= wr_on;
          sh_x[i]  <= wr_x;
          sh_y[i]  <= wr_y;
        end
        if (frame_sync) begin
          if (wr_en && (wr_idx == IW'(i))) begin
            act_on[i] <= wr_on;
            act_x[i]  <= wr_x;
            act_y[i]  <= wr_y;
          end else begin
            act_on[i] <= sh_on[i];
            act_x[i]  <= sh_x[i];
            act_y[i]  <= sh_y[i];
          end
        end
      end
    end
  end

  // Stage 0: capture the pixel coordinate
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      valid0 <= 1'b0;
      x0     <= '0;
      y0     <= '0;
    end else begin
      valid0 <= pix_valid;
      x0     <= DrawX;
      y0     <= DrawY;
    end
  end

  assign px0 = {1'b0, x0};
  assign py0 = {1'b0, y0};

  // Hit test; scanning from the top slot down leaves the lowest matching slot selected
  always_comb begin
    any_hit = 1'b0;
    x_sel   = '0;
    y_sel   = '0;
    for (int i = int'(NUM_INST) - 1; i >= 0; i--) begin
      if (act_on[i] &&
          (px0 >= {1'b0, act_x[i]}) && (px0 < ({1'b0, act_x[i]} + SW'(SPR_W))) &&
          (py0 >= {1'b0, act_y[i]}) && (py0 < ({1'b0, act_y[i]} + SW'(SPR_H)))) begin
        any_hit = 1'b1;
        x_sel   = act_x[i];
        y_sel   = act_y[i];
      end
    end
  end

  assign off_x     = x0 - x_sel;
  assign off_y     = y0 - y_sel;
  assign addr_full = (AW'(off_y) * AW'(SPR_W)) + AW'(off_x);
  assign rom_addr  = (any_hit && valid0) ? addr_full : '0;

  // Stage 1: ROM data returns combinationally, register it with the hit flag
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      valid1 <= 1'b0;
      hit1   <= 1'b0;
      data1  <= '0;
    end else begin
      valid1 <= valid0;
      hit1   <= any_hit && valid0;
      data1  <= rom_data;
    end
  end

  // Stage 2: transparent palette entries are not hits
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_idx   <= '0;
    end else begin
      out_valid <= valid1;
      out_hit   <= hit1 && (data1 != TRANSP);
      out_idx   <= (hit1 && (data1 != TRANSP)) ? data1 : '0;
    end
  end

endmodule

// File: tb/tb_wall_v_draw.sv
// Bench for wall_v_draw: directed placements plus randomized pixels and table writes,
// checked against a placement-list model and an expectation queue keyed by cycle.
module tb_wall_v_draw;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_sync;
  logic       pix_valid;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic       wr_on;
  logic [8:0] rom_addr;
  logic [3:0] rom_data;
  logic       out_valid;
  logic       out_hit;
  logic [3:0] out_idx;

  always #5 Clk = ~Clk;

  wall_v_draw dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_sync(frame_sync), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x),
    .wr_y(wr_y), .wr_on(wr_on), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_hit(out_hit), .out_idx(out_idx)
  );

  // Sprite ROM: 0 = table contents, 1 = everything transparent, 2 = everything 4'hF
  logic [3:0] rom_mem [396];
  int rom_mode;

  always_comb begin
    if (rom_mode == 1)           rom_data = 4'h0;
    else if (rom_mode == 2)      rom_data = 4'hF;
    else if (rom_addr < 9'd396)  rom_data = rom_mem[rom_addr];
    else                         rom_data = 4'h0;
  end

  // Placement-table model
  int m_sh_on [8];
  int m_sh_x  [8];
  int m_sh_y  [8];
  int m_ac_on [8];
  int m_ac_x  [8];
  int m_ac_y  [8];

  typedef struct { int due; int addr; } aexp_t;
  typedef struct { int due; int v; int hit; int idx; } oexp_t;
  aexp_t aq[$];
  oexp_t oq[$];

  int cyc;
  int n_chk;
  int n_fail;
  bit sweep_on;
  int sweep_valid, sweep_hits, sweep_first, sweep_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void model(input int x, input int y, output bit h, output int a);
    h = 0;
    a = 0;
    for (int i = 0; i < 8; i++) begin
      if (!h && m_ac_on[i] != 0 && x >= m_ac_x[i] && x < m_ac_x[i] + 18 &&
          y >= m_ac_y[i] && y < m_ac_y[i] + 22) begin
        h = 1;
        a = (y - m_ac_y[i]) * 18 + (x - m_ac_x[i]);
      end
    end
  endfunction

  function automatic int rom_at(input int a);
    if (rom_mode == 1) return 0;
    if (rom_mode == 2) return 15;
    return int'(rom_mem[a]);
  endfunction

  task automatic tick();
    @(posedge Clk);
    cyc++;
    @(negedge Clk);
    while (aq.size() > 0 && aq[0].due == cyc) begin
      chk("rom_addr", 32'(rom_addr), 32'(aq[0].addr));
      void'(aq.pop_front());
    end
    while (oq.size() > 0 && oq[0].due == cyc) begin
      chk("out_valid", 32'(out_valid), 32'(oq[0].v));
      chk("out_hit", 32'(out_hit), 32'(oq[0].hit));
      chk("out_idx", 32'(out_idx), 32'(oq[0].idx));
      void'(oq.pop_front());
    end
    if (sweep_on) begin
      if (out_valid) sweep_valid++;
      if (out_hit) begin
        if (sweep_first < 0) sweep_first = cyc;
        sweep_last = cyc;
        sweep_hits++;
      end
    end
  endtask

  // One clock: drive pixel and table inputs, update the model, queue expectations
  task automatic step_core(input bit v, input int x, input int y,
                           input bit we, input int wi, input int won, input int wx, input int wy,
                           input bit fs, input bit use_lit, input bit lit_hit, input int lit_addr);
    bit h;
    int a, d, oh;
    pix_valid  = v;
    DrawX      = 10'(x);
    DrawY      = 10'(y);
    wr_en      = we;
    wr_idx     = 3'(wi);
    wr_on      = won[0];
    wr_x       = 10'(wx);
    wr_y       = 10'(wy);
    frame_sync = fs;
    if (we) begin
      m_sh_on[wi] = won;
      m_sh_x[wi]  = wx;
      m_sh_y[wi]  = wy;
    end
    if (fs) begin
      m_ac_on = m_sh_on;
      m_ac_x  = m_sh_x;
      m_ac_y  = m_sh_y;
    end
    if (use_lit) begin
      h = lit_hit;
      a = lit_addr;
    end else begin
      model(x, y, h, a);
    end
    if (!(v && h)) a = 0;
    d  = rom_at(a);
    oh = (v && h && d != 0) ? 1 : 0;
    aq.push_back('{cyc + 1, a});
    oq.push_back('{cyc + 3, int'(v), oh, (oh != 0) ? d : 0});
    tick();
  endtask

  task automatic pix(input int x, input int y);
    step_core(1, x, y, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix_lit(input int x, input int y, input bit h, input int a);
    step_core(1, x, y, 0, 0, 0, 0, 0, 0, 1, h, a);
  endtask

  task automatic idle(input int n);
    repeat (n) step_core(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int i, input int on, input int x, input int y, input bit fs);
    step_core(0, 0, 0, 1, i, on, x, y, fs, 0, 0, 0);
  endtask

  task automatic commit();
    step_core(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    aq.delete();
    oq.delete();
    for (int i = 0; i < 8; i++) begin
      m_sh_on[i] = 0; m_sh_x[i] = 0; m_sh_y[i] = 0;
      m_ac_on[i] = 0; m_ac_x[i] = 0; m_ac_y[i] = 0;
    end
    Reset_n = 1'b0;
    repeat (n) begin
      pix_valid  = 1'b1;
      DrawX      = 10'($urandom_range(0, 639));
      DrawY      = 10'($urandom_range(0, 479));
      wr_en      = 1'b1;
      wr_idx     = 3'($urandom_range(0, 7));
      wr_on      = 1'b1;
      wr_x       = DrawX;
      wr_y       = DrawY;
      frame_sync = 1'b1;
      tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_hit", 32'(out_hit), 0);
      chk("rst_out_idx", 32'(out_idx), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
    end
    Reset_n = 1'b1;
  endtask

  initial begin
    int s, x, y;
    cyc = 0; n_chk = 0; n_fail = 0; rom_mode = 0; sweep_on = 0;
    pix_valid = 0; DrawX = '0; DrawY = '0; wr_en = 0; wr_idx = '0;
    wr_x = '0; wr_y = '0; wr_on = 0; frame_sync = 0; Reset_n = 1'b0;
    for (int i = 0; i < 396; i++)
      rom_mem[i] = (i % 23 == 7) ? 4'h0 : 4'($urandom_range(1, 15));
    rom_mem[0] = 4'hF; rom_mem[395] = 4'hF; rom_mem[30] = 4'hA;
    rom_mem[27] = 4'h3; rom_mem[171] = 4'h5;

    // Reset, then an empty table never hits
    do_reset(2);
    repeat (20) pix($urandom_range(0, 639), $urandom_range(0, 479));

    // Single sprite corners and just-outside pixels
    wr(0, 1, 100, 50, 0);
    commit();
    pix_lit(100, 50, 1, 0);
    pix_lit(117, 71, 1, 395);
    pix_lit(118, 50, 0, 0);
    pix_lit(100, 72, 0, 0);
    pix_lit(99, 50, 0, 0);
    pix_lit(100, 49, 0, 0);

    // Shadow isolation and same-cycle write-through commit
    wr(0, 1, 300, 50, 0);
    pix_lit(100, 50, 1, 0);
    commit();
    pix_lit(100, 50, 0, 0);
    pix_lit(300, 50, 1, 0);
    wr(0, 1, 400, 60, 1);
    pix_lit(400, 60, 1, 0);
    pix_lit(300, 50, 0, 0);

    // Overlap priority
    wr(2, 1, 200, 100, 0);
    wr(5, 1, 210, 100, 0);
    commit();
    pix_lit(212, 101, 1, 30);
    pix_lit(219, 101, 1, 27);

    // Clipping at the bottom-right corner, no wrap at the origin
    wr(1, 1, 630, 470, 0);
    commit();
    pix_lit(639, 479, 1, 171);
    pix_lit(0, 0, 0, 0);
    pix_lit(5, 5, 0, 0);

    // Transparent ROM data suppresses the hit
    rom_mode = 1;
    pix_lit(400, 60, 1, 0);
    idle(1);
    rom_mode = 0;
    idle(3);

    // Full-line sweep through slot 0 at row 70
    rom_mode = 2;
    sweep_valid = 0; sweep_hits = 0; sweep_first = -1; sweep_last = -1;
    sweep_on = 1;
    for (int i = 0; i < 640; i++) pix(i, 70);
    idle(4);
    sweep_on = 0;
    rom_mode = 0;
    chk("sweep_valid", 32'(sweep_valid), 640);
    chk("sweep_hits", 32'(sweep_hits), 18);
    chk("sweep_run", 32'(sweep_last - sweep_first + 1), 18);

    // Randomized pixels, writes and commits
    for (int n = 0; n < 1500; n++) begin
      bit v, we, fs;
      v  = ($urandom_range(0, 7) != 0);
      we = ($urandom_range(0, 9) == 0);
      fs = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, 7);
        x = m_ac_x[s] + $urandom_range(0, 19) - 1;
        y = m_ac_y[s] + $urandom_range(0, 23) - 1;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      step_core(v, x, y, we, $urandom_range(0, 7), $urandom_range(0, 3) != 0 ? 1 : 0,
                $urandom_range(0, 639), $urandom_range(0, 479), fs, 0, 0, 0);
    end
    idle(2);

    // Mid-frame reset empties the table
    pix(100, 50);
    do_reset(2);
    repeat (20) pix($urandom_range(0, 639), $urandom_range(0, 479));
    commit();
    repeat (20) pix($urandom_range(0, 639), $urandom_range(0, 479));
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
